// File: rtl/stack_file.sv
// stack_file: parameterised LIFO register stack with peek port and sticky error flags.
//   clock, reset    : single clock, synchronous active-high reset
//   op              : 0 NOP, 1 PUSH, 2 POP, 3 REPLACE, 4 POP2PUSH, 5 SWAP, 6 DUP, 7 CLEAR
//   wr_data         : operand for PUSH / REPLACE / POP2PUSH
//   rd_idx          : depth-relative peek index (0 = top), rd_data returns that entry
//   err_clr         : clears sticky overflow/underflow flags
//   tos, nos        : top / next-of-stack entries (0 when not present)
//   count,empty,full: occupancy
//   overflow, underflow : sticky error flags; op_err : one-cycle pulse for a rejected op
module stack_file #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [CW-1:0]    rd_idx,
  input  logic             err_clr,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic             op_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_PUSH     = 3'd1,
    OP_POP      = 3'd2,
    OP_REPLACE  = 3'd3,
    OP_POP2PUSH = 3'd4,
    OP_SWAP     = 3'd5,
    OP_DUP      = 3'd6,
    OP_CLEAR    = 3'd7
  } op_e;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             r_unf;
  logic             r_op_err;

  op_e              w_op;
  logic             w_ovf;
  logic             w_unf;
  logic             w_rej;
  logic [CW-1:0]    w_cnt_m1;
  logic [CW-1:0]    w_cnt_m2;
  logic [CW-1:0]    w_rd_pos;
  logic [AW-1:0]    w_i0;
  logic [AW-1:0]    w_i1;
  logic [AW-1:0]    w_i2;
  logic [AW-1:0]    w_ir;

  assign w_op     = op_e'(op);
  assign w_cnt_m1 = r_count - CW'(1);
  assign w_cnt_m2 = r_count - CW'(2);
  assign w_rd_pos = w_cnt_m1 - rd_idx;

  // Address slices are only consumed when the op is legal, so truncation
  // (e.g. count==DEPTH on a power-of-two depth) never selects a live entry.
  assign w_i0 = r_count[AW-1:0];
  assign w_i1 = w_cnt_m1[AW-1:0];
  assign w_i2 = w_cnt_m2[AW-1:0];
  assign w_ir = w_rd_pos[AW-1:0];

  always_comb begin
    w_ovf = 1'b0;
    w_unf = 1'b0;
    case (w_op)
      OP_PUSH:              w_ovf = (r_count == FULL_CNT);
      OP_POP, OP_REPLACE:   w_unf = (r_count == '0);
      OP_POP2PUSH, OP_SWAP: w_unf = (r_count < CW'(2));
      OP_DUP: begin
        // Underflow wins when both conditions could apply.
        w_unf = (r_count == '0);
        w_ovf = (r_count != '0) && (r_count == FULL_CNT);
      end
      default: ;
    endcase
    w_rej = w_ovf | w_unf;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mem    <= '{default: '0};
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_op_err <= 1'b0;
    end else begin
      r_op_err <= w_rej;
      // A new error in the same cycle as err_clr leaves the flag set.
      r_ovf    <= (r_ovf & ~err_clr) | w_ovf;
      r_unf    <= (r_unf & ~err_clr) | w_unf;
      if (!w_rej) begin
        case (w_op)
          OP_PUSH: begin
            r_mem[w_i0] <= wr_data;
            r_count     <= r_count + CW'(1);
          end
          OP_POP:     r_count <= w_cnt_m1;
          OP_REPLACE: r_mem[w_i1] <= wr_data;
          OP_POP2PUSH: begin
            r_mem[w_i2] <= wr_data;
            r_count     <= w_cnt_m1;
          end
          OP_SWAP: begin
            r_mem[w_i1] <= r_mem[w_i2];
            r_mem[w_i2] <= r_mem[w_i1];
          end
          OP_DUP: begin
            r_mem[w_i0] <= r_mem[w_i1];
            r_count     <= r_count + CW'(1);
          end
          OP_CLEAR: r_count <= '0;
          default: ;
        endcase
      end
    end
  end

  assign tos       = (r_count != '0)     ? r_mem[w_i1] : '0;
  assign nos       = (r_count >= CW'(2)) ? r_mem[w_i2] : '0;
  assign rd_data   = (rd_idx < r_count)  ? r_mem[w_ir] : '0;
  assign count     = r_count;
  assign empty     = (r_count == '0);
  assign full      = (r_count == FULL_CNT);
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign op_err    = r_op_err;

endmodule

// File: tb/tb_stack_file.sv
// tb_stack_file: directed-vector self-checking bench for stack_file (WIDTH=8, DEPTH=8).
module tb_stack_file;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, REPLACE = 3'd3,
                         P2P = 3'd4, SWAP = 3'd5, DUP = 3'd6, CLEAR = 3'd7;

  logic             clock = 1'b0;
  logic             reset;
  logic [2:0]       op;
  logic [WIDTH-1:0] wr_data;
  logic [CW-1:0]    rd_idx;
  logic             err_clr;
  logic [WIDTH-1:0] tos, nos, rd_data;
  logic [CW-1:0]    count;
  logic             empty, full, overflow, underflow, op_err;

  int n_checks = 0;
  int n_errors = 0;

  stack_file #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .op(op), .wr_data(wr_data), .rd_idx(rd_idx),
    .err_clr(err_clr), .tos(tos), .nos(nos), .rd_data(rd_data), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow),
    .op_err(op_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one op for one clock edge, then sample 1 time unit after the edge.
  task automatic step(input logic [2:0] o, input logic [7:0] d = 8'h00, input logic clr = 1'b0);
    op      = o;
    wr_data = d;
    err_clr = clr;
    @(posedge clock);
    #1;
    op      = NOP;
    wr_data = '0;
    err_clr = 1'b0;
  endtask

  task automatic peek(input string tag, input logic [CW-1:0] idx, input logic [7:0] exp);
    rd_idx = idx;
    #1;
    check(tag, rd_data, exp);
    rd_idx = '0;
  endtask

  initial begin
    reset = 1'b1; op = NOP; wr_data = '0; rd_idx = '0; err_clr = 1'b0;
    step(NOP);
    step(NOP);
    reset = 1'b0;
    check("rst_count", count, 0);
    check("rst_tos", tos, 0);
    check("rst_nos", nos, 0);
    check("rst_rd", rd_data, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);
    check("rst_operr", op_err, 0);

    // Basic pushes and peeks
    step(PUSH, 8'h11);
    step(PUSH, 8'h22);
    step(PUSH, 8'h33);
    check("push3_count", count, 3);
    check("push3_tos", tos, 8'h33);
    check("push3_nos", nos, 8'h22);
    peek("peek0", 0, 8'h33);
    peek("peek1", 1, 8'h22);
    peek("peek2", 2, 8'h11);
    peek("peek3", 3, 8'h00);
    peek("peek15", 15, 8'h00);

    // SWAP and POP2PUSH
    step(SWAP);
    check("swap_tos", tos, 8'h22);
    check("swap_nos", nos, 8'h33);
    check("swap_count", count, 3);
    check("swap_operr", op_err, 0);
    step(P2P, 8'h55);
    check("p2p_count", count, 2);
    check("p2p_tos", tos, 8'h55);
    check("p2p_nos", nos, 8'h11);

    // Fill to full, then overflow
    for (int i = 1; i <= 6; i++) step(PUSH, 8'(i));
    check("fill_count", count, 8);
    check("fill_full", full, 1);
    check("fill_tos", tos, 8'h06);
    peek("fill_peek7", 7, 8'h11);
    step(PUSH, 8'hAA);
    check("ovf_count", count, 8);
    check("ovf_tos", tos, 8'h06);
    check("ovf_flag", overflow, 1);
    check("ovf_operr", op_err, 1);
    check("ovf_full", full, 1);
    step(NOP);
    check("ovf_operr_drop", op_err, 0);
    check("ovf_sticky", overflow, 1);
    step(DUP);
    check("dupf_ovf", overflow, 1);
    check("dupf_operr", op_err, 1);
    check("dupf_count", count, 8);
    check("dupf_tos", tos, 8'h06);
    check("dupf_nos", nos, 8'h05);
    step(NOP, 8'h00, 1'b1);
    check("clr_ovf", overflow, 0);

    // Empty-stack rejections
    step(CLEAR);
    check("clear_empty", empty, 1);
    step(POP);
    check("pop_e_unf", underflow, 1);
    check("pop_e_count", count, 0);
    check("pop_e_operr", op_err, 1);
    step(REPLACE, 8'h66);
    check("rep_e_tos", tos, 0);
    check("rep_e_count", count, 0);
    step(NOP, 8'h00, 1'b1);
    step(DUP);
    check("dup_e_unf", underflow, 1);
    check("dup_e_ovf", overflow, 0);
    check("dup_e_count", count, 0);
    step(NOP, 8'h00, 1'b1);
    check("clr_unf", underflow, 0);

    // One entry: SWAP and POP2PUSH rejected
    step(PUSH, 8'h77);
    step(SWAP);
    check("swap1_unf", underflow, 1);
    check("swap1_operr", op_err, 1);
    check("swap1_tos", tos, 8'h77);
    check("swap1_count", count, 1);
    step(NOP, 8'h00, 1'b1);
    step(P2P, 8'h99);
    check("p2p1_unf", underflow, 1);
    check("p2p1_tos", tos, 8'h77);
    check("p2p1_count", count, 1);
    step(REPLACE, 8'h88);
    check("rep_tos", tos, 8'h88);
    check("rep_count", count, 1);
    step(NOP, 8'h00, 1'b1);
    check("clr_both_ovf", overflow, 0);
    check("clr_both_unf", underflow, 0);

    // err_clr coincident with a new underflow
    step(POP);
    check("pop_last_count", count, 0);
    check("pop_last_tos", tos, 0);
    step(POP, 8'h00, 1'b1);
    check("clr_vs_err_unf", underflow, 1);

    // DUP with one entry, then build to 5 entries
    step(PUSH, 8'h44);
    step(DUP);
    check("dup_count", count, 2);
    check("dup_tos", tos, 8'h44);
    check("dup_nos", nos, 8'h44);
    step(PUSH, 8'hA1);
    step(PUSH, 8'hA2);
    step(PUSH, 8'hA3);
    check("five_count", count, 5);

    // Reset wins over concurrent PUSH and err_clr
    reset = 1'b1;
    step(PUSH, 8'hEE, 1'b1);
    reset = 1'b0;
    check("mrst_count", count, 0);
    check("mrst_tos", tos, 0);
    check("mrst_unf", underflow, 0);
    check("mrst_ovf", overflow, 0);
    check("mrst_empty", empty, 1);

    // CLEAR with 4 entries keeps error flags
    step(POP);
    for (int i = 0; i < 4; i++) step(PUSH, 8'(8'hC0 + i));
    check("four_count", count, 4);
    check("four_tos", tos, 8'hC3);
    step(CLEAR);
    check("clr4_empty", empty, 1);
    check("clr4_count", count, 0);
    check("clr4_unf", underflow, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
